fetch_unit: RTL and testbench

- Front-end consumer of the next-PC selector. It owns the PC register and the IF/ID pipeline register.
- It issues instruction-memory requests over a req/gnt/rvalid interface and advances to `next_pc` when an instruction is accepted into IF/ID.
- On `flush` it redirects to `next_pc`, kills the IF/ID contents and discards any in-flight response.
- It supplies `pc_plus4` back to the next-PC selector and honours `stall` from the hazard unit.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_hold_buf.sv | 37 +++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    // Bubble instruction: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus (req/gnt/rvalid, one outstanding).
interface fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched {pc, instr} while IF/ID is stalled.
module fetch_hold_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    // Load captures a new entry; clear empties it (the two never coincide).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            instr_q <= in_instr;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and the IF/ID register, issues imem requests,
// handles stall (via hold buffer) and flush (redirect + drain stale response).
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            flush,
    input  logic            stall,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] fetch_pc,
    fetch_if.master         imem,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
);
    import fetch_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_pc, buf_instr;
    logic            deliver;
    logic [XLEN-1:0] deliver_pc, deliver_instr;

    fetch_hold_buf #(
        .XLEN (XLEN)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .in_pc    (pc_q),
        .in_instr (imem.rdata),
        .valid    (buf_valid),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );

    // Next-state, PC and IF/ID update; flush > stall > load > bubble.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = pc_q;
        deliver_instr = imem.rdata;

        unique case (state_q)
            REQ: begin
                // A granted request that is flushed still gets a response to discard.
                if (imem.gnt) state_d = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem.rvalid ? REQ : DRAIN;
                end else if (imem.rvalid) begin
                    if (stall) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    buf_clear = 1'b1;
                    state_d   = REQ;
                end else if (!stall && buf_valid) begin
                    deliver       = 1'b1;
                    deliver_pc    = buf_pc;
                    deliver_instr = buf_instr;
                    buf_clear     = 1'b1;
                    state_d       = REQ;
                end
            end
            DRAIN: begin
                if (imem.rvalid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        if (flush || deliver) pc_d = next_pc;

        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = deliver_pc;
                ifid_instr_d = deliver_instr;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign imem.req    = (state_q == REQ) && !rst;
    assign imem.addr   = pc_q;
    assign fetch_pc    = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign if_id_valid = ifid_valid_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected IF/ID loads.
module tb_fetch_unit;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst, flush, stall;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] next_pc, pc_plus4, fetch_pc;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc, if_id_instr;
    logic            prev_stall;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch_if #(.XLEN(XLEN)) imem ();

    // Sequential fetch unless redirecting.
    assign next_pc = flush ? redir_pc : pc_plus4;

    fetch_unit #(
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .flush       (flush),
        .stall       (stall),
        .pc_plus4    (pc_plus4),
        .fetch_pc    (fetch_pc),
        .imem        (imem.master),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) prev_stall <= stall;

    // A valid IF/ID that was not merely held by stall is a fresh load.
    always @(negedge clk) begin
        if (!rst && if_id_valid && !prev_stall) begin
            check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                check("sb_pc", if_id_pc, e[63:32]);
                check("sb_instr", if_id_instr, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Grant the pending request, then return rdata the following cycle.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
        imem.gnt = 1'b1;
        tick();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        sb.push_back({pc, data});
        tick();
        imem.rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; redir_pc = '0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        tick();
        tick();
        check("rst_req", 32'(imem.req), 32'd0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_ifid_pc", if_id_pc, 32'h0);

        // 1: out of reset
        rst = 1'b0;
        #1;
        check("t1_req", 32'(imem.req), 32'd1);
        check("t1_addr", imem.addr, 32'h0);
        check("t1_valid", 32'(if_id_valid), 32'd0);
        check("t1_instr", if_id_instr, NOP);
        check("t1_plus4", pc_plus4, 32'h4);

        // 2: first fetch, result one cycle after rvalid
        fetch_one(32'h0, 32'h0050_0093);
        check("t2_valid", 32'(if_id_valid), 32'd1);
        check("t2_pc", if_id_pc, 32'h0);
        check("t2_instr", if_id_instr, 32'h0050_0093);
        check("t2_addr", imem.addr, 32'h4);
        check("t2_req", 32'(imem.req), 32'd1);

        // 3: response arrives under a 3-cycle stall
        imem.gnt = 1'b1;
        tick();
        imem.gnt    = 1'b0;
        stall       = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h00A0_0113;
        tick();
        imem.rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t3_hold_pc", fetch_pc, 32'h4);
            check("t3_hold_req", 32'(imem.req), 32'd0);
            check("t3_hold_valid", 32'(if_id_valid), 32'd0);
            check("t3_hold_instr", if_id_instr, NOP);
            tick();
        end
        check("t3_hold_pc_last", fetch_pc, 32'h4);
        stall = 1'b0;
        sb.push_back({32'h4, 32'h00A0_0113});
        tick();
        check("t3_instr", if_id_instr, 32'h00A0_0113);
        check("t3_pc", if_id_pc, 32'h4);
        check("t3_addr", imem.addr, 32'h8);

        // 4: flush in WAIT, late response must be dropped
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0;
        flush    = 1'b1;
        redir_pc = 32'h40;
        tick();
        flush = 1'b0;
        check("t4_drain_req", 32'(imem.req), 32'd0);
        check("t4_valid0", 32'(if_id_valid), 32'd0);
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        tick();
        imem.rvalid = 1'b0;
        check("t4_valid1", 32'(if_id_valid), 32'd0);
        check("t4_instr", if_id_instr, NOP);
        check("t4_req", 32'(imem.req), 32'd1);
        check("t4_addr", imem.addr, 32'h40);

        // 5: flush with stall while in HOLD
        imem.gnt = 1'b1;
        tick();
        imem.gnt    = 1'b0;
        stall       = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h1111_1111;
        tick();
        imem.rvalid = 1'b0;
        flush       = 1'b1;
        redir_pc    = 32'h80;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        check("t5_valid", 32'(if_id_valid), 32'd0);
        check("t5_pc", fetch_pc, 32'h80);
        check("t5_req", 32'(imem.req), 32'd1);
        fetch_one(32'h80, 32'h2222_2222);
        check("t5_next_addr", imem.addr, 32'h84);

        // 6: gnt withheld; redirect to 0x8 first, then flush to 0x100 mid-wait
        flush    = 1'b1;
        redir_pc = 32'h8;
        tick();
        flush = 1'b0;
        check("t6_c1_req", 32'(imem.req), 32'd1);
        check("t6_c1_addr", imem.addr, 32'h8);
        tick();
        check("t6_c2_req", 32'(imem.req), 32'd1);
        check("t6_c2_addr", imem.addr, 32'h8);
        flush    = 1'b1;
        redir_pc = 32'h100;
        tick();
        flush = 1'b0;
        check("t6_c3_req", 32'(imem.req), 32'd1);
        check("t6_c3_addr", imem.addr, 32'h100);
        fetch_one(32'h100, 32'h3333_3333);

        // Flush coinciding with gnt in REQ: drain, then refetch at target
        imem.gnt = 1'b1;
        flush    = 1'b1;
        redir_pc = 32'h200;
        tick();
        imem.gnt = 1'b0;
        flush    = 1'b0;
        check("t7_drain_req", 32'(imem.req), 32'd0);
        check("t7_pc", fetch_pc, 32'h200);
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h4444_4444;
        tick();
        imem.rvalid = 1'b0;
        check("t7_req", 32'(imem.req), 32'd1);
        check("t7_addr", imem.addr, 32'h200);
        check("t7_valid", 32'(if_id_valid), 32'd0);

        // pc_plus4 wraps
        flush    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check("wrap_plus4", pc_plus4, 32'h0);
        fetch_one(32'hFFFF_FFFC, 32'h5555_5555);
        check("wrap_addr", imem.addr, 32'h0);

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
